// File: rtl/toom8_pkg.sv
// Shared constants and types for the Toom-8 datapath (splitter and recomposer).
// TOOM8_RECOMP_RANGE_CHK_EN adds signed guard bits to the recomposer accumulator.
package toom8_pkg;

  localparam int unsigned LIMB_W    = 128;
  localparam int unsigned NUM_SPLIT = 8;
  localparam int unsigned NUM_COEFS = 2 * NUM_SPLIT - 1;
  localparam int unsigned SPLIT_W   = LIMB_W + 1;
  localparam int unsigned COEF_W    = 264;
  localparam int unsigned PROD_W    = 2048;
  localparam int unsigned IDX_W     = 4;
  localparam int unsigned SHAMT_W   = 11;

`ifdef TOOM8_RECOMP_RANGE_CHK_EN
  localparam int unsigned GUARD_W = 16;
`else
  localparam int unsigned GUARD_W = 0;
`endif
  localparam int unsigned ACC_W = PROD_W + GUARD_W;

  typedef logic signed [COEF_W-1:0] coef_t;
  typedef logic [PROD_W-1:0]        prod_t;
  typedef logic [ACC_W-1:0]         acc_t;
  typedef logic [IDX_W-1:0]         idx_t;

  typedef enum logic {
    ST_ACCUM = 1'b0,
    ST_OUT   = 1'b1
  } state_e;

  localparam idx_t LAST_IDX = IDX_W'(NUM_COEFS - 1);

endpackage

// File: rtl/toom8_shift_add.sv
// Places one signed coefficient at limb offset LIMB_W*idx and adds it to the accumulator.
module toom8_shift_add
  import toom8_pkg::*;
(
  input  acc_t  acc_i,
  input  coef_t coef_i,
  input  idx_t  idx_i,
  output acc_t  sum_c_o
);

  logic [SHAMT_W-1:0] shamt;
  acc_t               ext;

  always_comb begin
    shamt   = SHAMT_W'(idx_i) << $clog2(LIMB_W);
    ext     = ACC_W'(coef_i);
    sum_c_o = acc_i + (ext << shamt);
  end

endmodule

// File: rtl/toom8_recomposer.sv
// Toom-8 recomposer: accumulates 15 serial coefficients into a 2048-bit product.
// TOOM8_RECOMP_RANGE_CHK_EN flags sums that are negative or overflow PROD_W.
module toom8_recomposer
  import toom8_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              coef_valid_i,
  output logic              coef_ready_o,
  input  logic [COEF_W-1:0] coef_data_i,
  input  logic              coef_last_i,
  output logic              prod_valid_o,
  input  logic              prod_ready_i,
  output logic [PROD_W-1:0] product_o,
  output logic              prod_err_o
);

  state_e state_q, state_d;
  acc_t   acc_q, acc_d;
  idx_t   idx_q, idx_d;
  logic   err_q, err_d;
  logic   coef_ready_q, coef_ready_d;
  logic   prod_valid_q, prod_valid_d;
  prod_t  product_q, product_d;
  logic   prod_err_q, prod_err_d;

  acc_t   sum_c;
  logic   accept_c;
  logic   beat_err_c;
  logic   range_err_c;

  toom8_shift_add u_shift_add (
    .acc_i   (acc_q),
    .coef_i  (coef_t'(coef_data_i)),
    .idx_i   (idx_q),
    .sum_c_o (sum_c)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= ST_ACCUM;
      acc_q        <= '0;
      idx_q        <= '0;
      err_q        <= 1'b0;
      coef_ready_q <= 1'b0;
      prod_valid_q <= 1'b0;
      product_q    <= '0;
      prod_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      idx_q        <= idx_d;
      err_q        <= err_d;
      coef_ready_q <= coef_ready_d;
      prod_valid_q <= prod_valid_d;
      product_q    <= product_d;
      prod_err_q   <= prod_err_d;
    end
  end

  // Beat 14 always closes the frame; coef_last only contributes to the error flag.
  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    idx_d        = idx_q;
    err_d        = err_q;
    coef_ready_d = coef_ready_q;
    prod_valid_d = prod_valid_q;
    product_d    = product_q;
    prod_err_d   = prod_err_q;

    accept_c   = coef_valid_i && coef_ready_q;
    beat_err_c = (idx_q == LAST_IDX) ? !coef_last_i : coef_last_i;
`ifdef TOOM8_RECOMP_RANGE_CHK_EN
    range_err_c = |sum_c[ACC_W-1:PROD_W];
`else
    range_err_c = 1'b0;
`endif

    case (state_q)
      ST_ACCUM: begin
        coef_ready_d = 1'b1;
        if (accept_c) begin
          acc_d = sum_c;
          idx_d = idx_q + IDX_W'(1);
          err_d = err_q | beat_err_c;
          if (idx_q == LAST_IDX) begin
            state_d      = ST_OUT;
            coef_ready_d = 1'b0;
            prod_valid_d = 1'b1;
            product_d    = sum_c[PROD_W-1:0];
            prod_err_d   = err_q | beat_err_c | range_err_c;
          end
        end
      end
      ST_OUT: begin
        coef_ready_d = 1'b0;
        if (prod_ready_i) begin
          state_d      = ST_ACCUM;
          coef_ready_d = 1'b1;
          prod_valid_d = 1'b0;
          prod_err_d   = 1'b0;
          acc_d        = '0;
          idx_d        = '0;
          err_d        = 1'b0;
        end
      end
      default: state_d = ST_ACCUM;
    endcase
  end

  assign coef_ready_o = coef_ready_q;
  assign prod_valid_o = prod_valid_q;
  assign product_o    = product_q;
  assign prod_err_o   = prod_err_q;

endmodule

// File: tb/tb_toom8_recomposer.sv
// Directed self-checking bench for toom8_recomposer.
module tb_toom8_recomposer;
  import toom8_pkg::*;

  logic              clk;
  logic              rst_i;
  logic              coef_valid_i;
  logic              coef_ready_o;
  logic [COEF_W-1:0] coef_data_i;
  logic              coef_last_i;
  logic              prod_valid_o;
  logic              prod_ready_i;
  logic [PROD_W-1:0] product_o;
  logic              prod_err_o;

  int checks = 0;
  int errors = 0;

  coef_t fr [NUM_COEFS];

  toom8_recomposer dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .coef_valid_i (coef_valid_i),
    .coef_ready_o (coef_ready_o),
    .coef_data_i  (coef_data_i),
    .coef_last_i  (coef_last_i),
    .prod_valid_o (prod_valid_o),
    .prod_ready_i (prod_ready_i),
    .product_o    (product_o),
    .prod_err_o   (prod_err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input prod_t obs, input prod_t exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed hi=%h lo=%h expected hi=%h lo=%h diffbits=%0d",
             tag, obs[PROD_W-1:PROD_W-64], obs[63:0], exp[PROD_W-1:PROD_W-64], exp[63:0],
             $countones(obs ^ exp));
    end
  endtask

  task automatic clear_frame();
    for (int k = 0; k < NUM_COEFS; k++) fr[k] = '0;
  endtask

  task automatic send_beat(input coef_t d, input logic last);
    int n;
    n = 0;
    coef_valid_i = 1'b1;
    coef_data_i  = d;
    coef_last_i  = last;
    while (!coef_ready_o && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("ready_wait", prod_t'(coef_ready_o), prod_t'(1));
    @(posedge clk); #1;
    coef_valid_i = 1'b0;
    coef_last_i  = 1'b0;
  endtask

  task automatic run_frame(input int last_pos, input bit gaps);
    for (int k = 0; k < NUM_COEFS; k++) begin
      if (k == NUM_COEFS - 1) chk("valid_before_last", prod_t'(prod_valid_o), prod_t'(0));
      send_beat(fr[k], k == last_pos);
      if (gaps && k < NUM_COEFS - 1) repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
    end
  endtask

  task automatic check_out(input string tag, input prod_t exp_p, input logic exp_e);
    chk({tag, "_valid"}, prod_t'(prod_valid_o), prod_t'(1));
    chk({tag, "_product"}, product_o, exp_p);
    chk({tag, "_err"}, prod_t'(prod_err_o), prod_t'(exp_e));
    @(posedge clk); #1;
    chk({tag, "_valid_drop"}, prod_t'(prod_valid_o), prod_t'(0));
    chk({tag, "_ready_back"}, prod_t'(coef_ready_o), prod_t'(1));
  endtask

  initial begin
    prod_t exp_p;
    coef_t sq;
    coef_t nk;
    logic  wrap_err;
    prod_t held_p;

    rst_i        = 1'b1;
    coef_valid_i = 1'b0;
    coef_data_i  = '0;
    coef_last_i  = 1'b0;
    prod_ready_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", prod_t'(coef_ready_o), prod_t'(0));
    chk("rst_valid", prod_t'(prod_valid_o), prod_t'(0));
    chk("rst_product", product_o, prod_t'(0));
    chk("rst_err", prod_t'(prod_err_o), prod_t'(0));
    rst_i = 1'b0;
    chk("ready_still_low", prod_t'(coef_ready_o), prod_t'(0));
    @(posedge clk); #1;
    chk("ready_rise", prod_t'(coef_ready_o), prod_t'(1));

    // c0 = 5
    clear_frame();
    fr[0] = coef_t'(5);
    run_frame(14, 1'b0);
    check_out("c0_5", prod_t'(5), 1'b0);

    // c0 = -1, c1 = 1
    clear_frame();
    fr[0] = '1;
    fr[1] = coef_t'(1);
    exp_p = (prod_t'(1) << 128) - prod_t'(1);
    run_frame(14, 1'b0);
    check_out("neg_carry", exp_p, 1'b0);

    // c14 = 1
    clear_frame();
    fr[14] = coef_t'(1);
    run_frame(14, 1'b0);
    check_out("top_limb", prod_t'(1) << 1792, 1'b0);

    // c14 = 2^256 wraps out of the product
`ifdef TOOM8_RECOMP_RANGE_CHK_EN
    wrap_err = 1'b1;
`else
    wrap_err = 1'b0;
`endif
    clear_frame();
    fr[14] = coef_t'(1) << 256;
    run_frame(14, 1'b0);
    check_out("wrap_out", prod_t'(0), wrap_err);

    // X = Y = 2^1024-1: every limb is 2^128-1, c_k = n_k * (2^128-1)^2
    sq = (coef_t'(1) << 256) - (coef_t'(1) << 129) + coef_t'(1);
    for (int k = 0; k < NUM_COEFS; k++) begin
      nk    = COEF_W'((k < 8) ? (k + 1) : (15 - k));
      fr[k] = sq * nk;
    end
    exp_p = prod_t'(0) - (prod_t'(1) << 1025) + prod_t'(1);
    run_frame(14, 1'b0);
    check_out("golden", exp_p, 1'b0);
    run_frame(14, 1'b1);
    check_out("golden_gaps", exp_p, 1'b0);

    // Early coef_last with output backpressure
    clear_frame();
    fr[0] = coef_t'(5);
    prod_ready_i = 1'b0;
    run_frame(3, 1'b0);
    chk("bp_valid", prod_t'(prod_valid_o), prod_t'(1));
    chk("bp_product", product_o, prod_t'(5));
    chk("bp_err", prod_t'(prod_err_o), prod_t'(1));
    held_p       = product_o;
    coef_valid_i = 1'b1;
    coef_data_i  = COEF_W'(1);
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      chk("bp_hold_product", product_o, held_p);
      chk("bp_hold_err", prod_t'(prod_err_o), prod_t'(1));
      chk("bp_hold_valid", prod_t'(prod_valid_o), prod_t'(1));
      chk("bp_no_ready", prod_t'(coef_ready_o), prod_t'(0));
    end
    coef_valid_i = 1'b0;
    prod_ready_i = 1'b1;
    @(posedge clk); #1;
    chk("bp_release", prod_t'(prod_valid_o), prod_t'(0));

    // Missing coef_last on beat 14
    clear_frame();
    fr[2] = coef_t'(3);
    run_frame(15, 1'b0);
    check_out("no_last", prod_t'(3) << 256, 1'b1);

    // Reset after 7 beats discards the partial frame
    for (int k = 0; k < 7; k++) send_beat(coef_t'(1), 1'b0);
    rst_i = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_ready", prod_t'(coef_ready_o), prod_t'(0));
    chk("mid_rst_valid", prod_t'(prod_valid_o), prod_t'(0));
    chk("mid_rst_product", product_o, prod_t'(0));
    rst_i = 1'b0;
    clear_frame();
    fr[0] = coef_t'(7);
    run_frame(14, 1'b0);
    check_out("after_rst", prod_t'(7), 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
